// File: rtl/mem_stage_dmem.sv
// mem_stage_dmem: memory-stage data RAM with M/WB register and a host req/ack port using idle pipeline cycles
module mem_stage_dmem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64,
  parameter int REG_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WRegEn_M,
  input  logic              WMemEn_M,
  input  logic [ADDR_W-1:0] R1_out_M,
  input  logic [DATA_W-1:0] R2_out_M,
  input  logic [REG_W-1:0]  WReg1_M,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              WRegEn_WB,
  output logic [REG_W-1:0]  WReg1_WB,
  output logic [DATA_W-1:0] WData_WB
);
  typedef enum logic [1:0] {IDLE, RESP, DROP} state_t;
  state_t            state_q;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic              host_go, we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  always_comb begin
    host_go = state_q == IDLE && host_req && !(WRegEn_M || WMemEn_M);
    we      = !rst && (WMemEn_M || (host_go && host_we));
    waddr   = host_go ? host_addr : R1_out_M;
    wdata   = host_go ? host_wdata : R2_out_M;
  end
  assign host_ack = state_q == RESP;
  // RAM is never reset; reads below see the pre-edge word (read-first)
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      WRegEn_WB  <= 1'b0;
      WReg1_WB   <= '0;
      WData_WB   <= '0;
      host_rdata <= '0;
    end else begin
      WRegEn_WB <= WRegEn_M;
      WReg1_WB  <= WReg1_M;
      WData_WB  <= mem[R1_out_M];
      if (host_go && !host_we) host_rdata <= mem[host_addr];
      state_q <= host_go ? RESP :
                 state_q == RESP ? DROP :
                 (state_q == DROP && !host_req) ? IDLE : state_q;
    end
  end
endmodule
